alu_share_arbiter: RTL and testbench

//  Shares one external 8-bit ALU (alu_8bit, opcodes 000..111) between NREQ requesters.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_8bit.sv | 29 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 32 +++
 rtl/alu_share_arbiter.sv | 116 +++++++++++
 tb/tb_alu_share_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: opcode values, FSM states, default widths.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OPW   = 3;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_NAND = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU shared by the arbiter; carry is carry-out for ADD, borrow for SUB, 0 otherwise.
// Zero latency, no flow control.
module alu_8bit
  import alu_pkg::*;
(
  input  logic [ALU_WIDTH-1:0] a_i,
  input  logic [ALU_WIDTH-1:0] b_i,
  input  logic [ALU_OPW-1:0]   op_i,
  output logic [ALU_WIDTH-1:0] result_o,
  output logic                 carry_o
);

  always_comb begin
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD:  {carry_o, result_o} = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  {carry_o, result_o} = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_NAND: result_o = ~(a_i & b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo NREQ.
// Pure combinational, zero latency.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  grant_idx_o,
  output logic            grant_vld_o
);

  int j;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_vld_o = 1'b0;
    j           = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!grant_vld_o && req_i[j]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = IDW'(j);
        grant_o[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external ALU among NREQ requesters: round-robin accept, one execute cycle, held response.
// Accept at edge n gives resp_valid from cycle n+2; req_ready stays low until the response is taken.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = ALU_WIDTH,
  parameter  int OPW   = ALU_OPW,
  parameter  int CNTW  = 16,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_op,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_result,
  output logic                  resp_carry,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPW-1:0]        alu_op,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_carry,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [OPW-1:0]   op_q;
  logic             carry_q;
  logic [IDW-1:0]   id_q, ptr_q, id_inc;
  logic [CNTW-1:0]  cnt_q;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
  logic             accept, resp_done;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign accept    = (state_q == ST_IDLE) && grant_vld;
  assign resp_done = (state_q == ST_RESP) && resp_ready[id_q];
  assign id_inc    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    busy       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_vld) begin
          req_ready = grant;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        resp_valid = NREQ'(1) << id_q;
        if (resp_ready[id_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q  <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
        b_q  <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
        op_q <= req_op[int'(grant_idx)*OPW +: OPW];
        id_q <= grant_idx;
      end
      // ALU output is only valid against the operands held during EXEC
      if (state_q == ST_EXEC) begin
        res_q   <= alu_result;
        carry_q <= alu_carry;
      end
      if (resp_done) begin
        ptr_q <= id_inc;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign resp_result = res_q;
  assign resp_carry  = carry_q;
  assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a transaction-level reference model checked every cycle.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int OPW  = 3;
  localparam int CNTW = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a = '0;
  logic [NREQ*W-1:0] req_b = '0;
  logic [NREQ*OPW-1:0] req_op = '0;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready = '0;
  logic [W-1:0]      resp_result;
  logic              resp_carry;
  logic [W-1:0]      alu_a, alu_b, alu_result;
  logic [OPW-1:0]    alu_op;
  logic              alu_carry;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .busy(busy), .op_count(op_count)
  );

  alu_8bit u_alu (.a_i(alu_a), .b_i(alu_b), .op_i(alu_op), .result_o(alu_result), .carry_o(alu_carry));

  int vectors = 0;
  int fails   = 0;
  int bad_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // requester-side state
  logic [NREQ-1:0] pending = '0, auto_mask = '0, rdy_seen = '0;
  logic [W-1:0]    pa[NREQ], pb[NREQ];
  logic [OPW-1:0]  pop[NREQ];
  int              gq[$];
  logic [W-1:0]    res_seen[NREQ];
  logic            car_seen[NREQ];

  // reference model: one transaction in flight, described by who/what/how long ago
  bit          m_busy = 0;
  int          m_age = 0, m_id = 0, m_ptr = 0, m_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [OPW-1:0] m_op = '0;
  logic        m_c = 1'b0;

  function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {(a < b) ? 1'b1 : 1'b0, 8'(a - b)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~(a | b)};
      3'd6: return {1'b0, ~(a & b)};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] eg, erv;
    int gi;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_result", {resp_carry, resp_result}, 0);
      m_busy = 0; m_age = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_c = 1'b0;
      rdy_seen = '0;
    end else begin
      eg = '0; gi = -1;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++)
          if (gi < 0 && req_valid[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
      if (gi >= 0) eg[gi] = 1'b1;
      erv = (m_busy && m_age >= 1) ? NREQ'(1) << m_id : '0;
      chk("req_ready", req_ready, eg);
      chk("resp_valid", resp_valid, erv);
      chk("busy", busy, m_busy);
      chk("alu_operands", {alu_op, alu_a, alu_b}, {m_op, m_a, m_b});
      chk("resp_data", {resp_carry, resp_result}, {m_c, m_res});
      chk("op_count", op_count, m_cnt);
      if (busy && req_ready != 0) bad_cnt++;
      if (req_ready != 0) gq.push_back($clog2(req_ready));
      if (resp_valid != 0) begin
        res_seen[$clog2(resp_valid)] = resp_result;
        car_seen[$clog2(resp_valid)] = resp_carry;
      end
      rdy_seen = req_ready;
      if (!m_busy) begin
        if (gi >= 0) begin
          m_busy = 1; m_age = 0; m_id = gi;
          m_a = pa[gi]; m_b = pb[gi]; m_op = pop[gi];
        end
      end else if (m_age == 0) begin
        m_age = 1;
        {m_c, m_res} = ref_alu(m_a, m_b, m_op);
      end else if (resp_ready[m_id]) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % NREQ;
        m_cnt  = (m_cnt + 1) % (1 << CNTW);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    pending   = (pending & ~rdy_seen) | auto_mask;
    req_valid = pending;
  endtask

  task automatic post(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [OPW-1:0] op);
    pa[i] = a; pb[i] = b; pop[i] = op;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_op[i*OPW +: OPW] = op;
    pending[i] = 1'b1;
    req_valid  = pending;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pending != 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pending = '0; auto_mask = '0; req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // 1: single ADD, latency and result
    resp_ready = '1;
    post(0, 8'h0F, 8'h01, OP_ADD);
    @(negedge clk); #1;
    chk("t1_ready_same_cycle", req_ready, 4'b0001);
    step();
    chk("t1_busy_exec", busy, 1);
    chk("t1_no_resp_in_exec", resp_valid, 0);
    step();
    @(negedge clk); #1;
    chk("t1_resp_valid", resp_valid, 4'b0001);
    chk("t1_result", resp_result, 8'h10);
    chk("t1_carry", resp_carry, 0);
    step();
    chk("t1_op_count", op_count, 1);
    wait_idle(20);

    // 2: all four requesters, order 0,1,2,3,0
    do_reset();
    gq.delete();
    post(0, 8'h01, 8'h02, OP_ADD);
    post(1, 8'hAA, 8'h55, OP_SUB);
    post(2, 8'hF0, 8'h0F, OP_OR);
    post(3, 8'hFF, 8'h01, OP_ADD);
    for (int n = 0; n < 20 && pending[0]; n++) step();
    post(0, 8'h80, 8'h80, OP_ADD);
    wait_idle(100);
    chk("t2_grant_count", gq.size(), 5);
    if (gq.size() == 5) begin
      chk("t2_g0", gq[0], 0); chk("t2_g1", gq[1], 1); chk("t2_g2", gq[2], 2);
      chk("t2_g3", gq[3], 3); chk("t2_g4", gq[4], 0);
    end
    chk("t2_r1", {car_seen[1], res_seen[1]}, 9'h055);
    chk("t2_r2", {car_seen[2], res_seen[2]}, 9'h0FF);
    chk("t2_r3", {car_seen[3], res_seen[3]}, 9'h100);
    chk("t2_r0", {car_seen[0], res_seen[0]}, 9'h100);

    // 3: requesters 0 and 2 held continuously
    do_reset();
    gq.delete();
    post(0, 8'h3C, 8'hC3, OP_XOR);
    post(2, 8'h05, 8'h07, OP_SUB);
    auto_mask = 4'b0101;
    repeat (14) step();
    auto_mask = '0;
    wait_idle(50);
    chk("t3_grant_count_min", (gq.size() >= 4) ? 1 : 0, 1);
    if (gq.size() >= 4) begin
      chk("t3_g0", gq[0], 0); chk("t3_g1", gq[1], 2);
      chk("t3_g2", gq[2], 0); chk("t3_g3", gq[3], 2);
    end
    chk("t3_r0", {car_seen[0], res_seen[0]}, 9'h0FF);
    chk("t3_r2", {car_seen[2], res_seen[2]}, 9'h1FE);

    // 4: response held under backpressure
    resp_ready = '0;
    post(1, 8'hCC, 8'hAA, OP_AND);
    for (int n = 0; n < 10 && !(m_busy && m_age >= 1); n++) step();
    post(0, 8'h01, 8'h01, OP_ADD);
    for (int n = 0; n < 5; n++) begin
      chk("t4_resp_valid_held", resp_valid, 4'b0010);
      chk("t4_result_held", resp_result, 8'h88);
      chk("t4_busy", busy, 1);
      chk("t4_no_accept", req_ready, 0);
      resp_ready = 4'b1101;
      step();
    end
    resp_ready = '1;
    wait_idle(50);

    // 5: reset mid-EXEC discards the operation; pointer restarts at 0
    post(2, 8'h11, 8'h22, OP_XOR);
    wait_idle(20);
    post(2, 8'h33, 8'h44, OP_ADD);
    for (int n = 0; n < 10 && pending[2]; n++) step();
    rst = 1'b1;
    pending = '0; req_valid = '0;
    #1;
    chk("t5_busy_cleared", busy, 0);
    chk("t5_alu_a_cleared", alu_a, 0);
    chk("t5_result_cleared", resp_result, 0);
    chk("t5_count_cleared", op_count, 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t5_no_resp", resp_valid, 0);
    end
    gq.delete();
    post(1, 8'h02, 8'h03, OP_NOR);
    post(3, 8'h04, 8'h05, OP_NAND);
    wait_idle(50);
    chk("t5_grant_count", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("t5_first_from_0", gq[0], 1);
      chk("t5_second", gq[1], 3);
    end

    // 6: 16 back-to-back ops, op_count wraps 15->0, ptr wraps 3->0
    do_reset();
    gq.delete();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREQ; i++) post(i, 8'(r * 16 + i), 8'(i + 1), 3'(r + i));
      wait_idle(100);
      if (r == 2) chk("t6_count_12", op_count, 12);
    end
    chk("t6_count_wrapped", op_count, 0);
    chk("t6_grant_count", gq.size(), 16);
    if (gq.size() == 16) begin
      chk("t6_g3", gq[3], 3);
      chk("t6_g4_wrap", gq[4], 0);
      chk("t6_g15", gq[15], 3);
    end

    chk("rdy_while_busy", bad_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
